// File: rtl/eship_projectile_pool_if.sv
// eship_projectile_pool_if: fire-request, render and status bundle for the projectile pool
interface eship_projectile_pool_if #(
  parameter int NSLOT = 8,
  parameter int NCH = 4,
  parameter int CW = $clog2(NSLOT + 1)
);
  logic [NCH-1:0] FireReq;
  logic [NCH-1:0][9:0] ShipX;
  logic [NCH-1:0][9:0] ShipY;
  logic [9:0] PlayerX;
  logic AimEn;
  logic [NSLOT-1:0] ProjColl;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [NSLOT-1:0] ProjOnVec;
  logic ProjOn;
  logic [9:0] ProjDistX;
  logic [9:0] ProjDistY;
  logic [CW-1:0] ActiveCount;
  logic FireDropped;
  modport master (
    output FireReq, ShipX, ShipY, PlayerX, AimEn, ProjColl, DrawX, DrawY,
    input ProjOnVec, ProjOn, ProjDistX, ProjDistY, ActiveCount, FireDropped
  );
  modport slave (
    input FireReq, ShipX, ShipY, PlayerX, AimEn, ProjColl, DrawX, DrawY,
    output ProjOnVec, ProjOn, ProjDistX, ProjDistY, ActiveCount, FireDropped
  );
endinterface

// File: rtl/eship_projectile_pool.sv
// eship_projectile_pool: enemy projectile slot pool with per-channel cooldown and pixel render mux
module eship_projectile_pool #(
  parameter int NSLOT = 8,
  parameter int NCH = 4,
  parameter int SPEED_Y = 2,
  parameter int XSTEP = 1,
  parameter int COOLDOWN = 30,
  parameter int GUN_X_OFF = 5,
  parameter int GUN_Y_OFF = 7,
  parameter int PROJ_W = 2,
  parameter int PROJ_H = 6,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input logic frame_clk,
  input logic Reset,
  eship_projectile_pool_if.slave bus
);
  localparam int CW = $clog2(NSLOT + 1);
  localparam int DW = $clog2(COOLDOWN + 1);
  logic [NSLOT-1:0] live, live_n, hit, taken;
  logic [9:0] x [NSLOT], x_n [NSLOT], y [NSLOT], y_n [NSLOT];
  logic signed [11:0] dx [NSLOT], dx_n [NSLOT], xs [NSLOT];
  logic [10:0] ys [NSLOT];
  logic [DW-1:0] cd [NCH], cd_n [NCH];
  logic [9:0] mx [NCH], my [NCH];
  logic signed [11:0] dxl [NCH];
  logic [CW-1:0] cnt, cnt_n;
  logic drop, drop_n, found, on;
  logic [9:0] dist_x, dist_y;
  for (genvar i = 0; i < NSLOT; i++) begin : g_s
    assign ys[i] = {1'b0, y[i]} + 11'(SPEED_Y);
    assign xs[i] = $signed({2'b0, x[i]}) + dx[i];
    assign hit[i] = live[i] && bus.DrawX >= x[i] && {1'b0, bus.DrawX} < {1'b0, x[i]} + 11'(PROJ_W)
                 && bus.DrawY >= y[i] && {1'b0, bus.DrawY} < {1'b0, y[i]} + 11'(PROJ_H);
  end
  for (genvar c = 0; c < NCH; c++) begin : g_c
    assign mx[c] = bus.ShipX[c] + 10'(GUN_X_OFF);
    assign my[c] = bus.ShipY[c] + 10'(GUN_Y_OFF);
    assign dxl[c] = (!bus.AimEn || bus.PlayerX == mx[c]) ? 12'sd0 :
                    bus.PlayerX > mx[c] ? 12'(XSTEP) : -12'(XSTEP);
  end
  always_comb begin
    live_n = live;
    drop_n = 1'b0;
    taken = '0;
    found = 1'b0;
    cnt_n = '0;
    for (int i = 0; i < NSLOT; i++) begin
      x_n[i] = x[i];
      y_n[i] = y[i];
      dx_n[i] = dx[i];
      if (live[i]) begin
        if (bus.ProjColl[i] || ys[i] > 11'(SCREEN_H - PROJ_H) || xs[i][11] || xs[i] > $signed(12'(SCREEN_W - PROJ_W)))
          live_n[i] = 1'b0;
        else begin
          y_n[i] = ys[i][9:0];
          x_n[i] = xs[i][9:0];
        end
      end
    end
    // only slots dead before this edge are allocatable; freshly retired ones wait a frame
    for (int c = 0; c < NCH; c++) begin
      cd_n[c] = cd[c] != '0 ? cd[c] - DW'(1) : '0;
      if (bus.FireReq[c] && cd[c] == '0) begin
        found = 1'b0;
        for (int s = 0; s < NSLOT; s++)
          if (!found && !live[s] && !taken[s]) begin
            found = 1'b1;
            taken[s] = 1'b1;
            live_n[s] = 1'b1;
            x_n[s] = mx[c];
            y_n[s] = my[c];
            dx_n[s] = dxl[c];
          end
        if (found) cd_n[c] = DW'(COOLDOWN);
        else drop_n = 1'b1;
      end
    end
    for (int i = 0; i < NSLOT; i++) cnt_n = cnt_n + CW'(live_n[i]);
  end
  always_comb begin
    on = 1'b0;
    dist_x = '0;
    dist_y = '0;
    for (int i = NSLOT - 1; i >= 0; i--)
      if (hit[i]) begin
        on = 1'b1;
        dist_x = bus.DrawX - x[i];
        dist_y = bus.DrawY - y[i];
      end
  end
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      live <= '0;
      drop <= 1'b0;
      cnt <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        x[i] <= '0;
        y[i] <= '0;
        dx[i] <= '0;
      end
      for (int c = 0; c < NCH; c++) cd[c] <= '0;
    end else begin
      live <= live_n;
      drop <= drop_n;
      cnt <= cnt_n;
      for (int i = 0; i < NSLOT; i++) begin
        x[i] <= x_n[i];
        y[i] <= y_n[i];
        dx[i] <= dx_n[i];
      end
      for (int c = 0; c < NCH; c++) cd[c] <= cd_n[c];
    end
  end
  assign bus.ProjOnVec = live;
  assign bus.ActiveCount = cnt;
  assign bus.FireDropped = drop;
  assign bus.ProjOn = on;
  assign bus.ProjDistX = dist_x;
  assign bus.ProjDistY = dist_y;
endmodule

// File: tb/tb_eship_projectile_pool.sv
// tb_eship_projectile_pool: directed checks of launch, cooldown, allocation, movement, retirement and render priority
module tb_eship_projectile_pool;
  logic frame_clk = 1'b0;
  logic Reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #10 frame_clk = ~frame_clk;
  eship_projectile_pool_if #(.NSLOT(8), .NCH(4)) bus ();
  eship_projectile_pool dut (.frame_clk(frame_clk), .Reset(Reset), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      @(negedge frame_clk);
    end
  endtask
  task automatic probe(input string tag, input int px, input int py, input logic on, input int ex, input int ey);
    bus.DrawX = 10'(px);
    bus.DrawY = 10'(py);
    #1;
    chk({tag, ".on"}, 32'(bus.ProjOn), 32'(on));
    chk({tag, ".dx"}, 32'(bus.ProjDistX), ex);
    chk({tag, ".dy"}, 32'(bus.ProjDistY), ey);
  endtask
  task automatic status(input string tag, input int vec, input int cnt, input int drop);
    chk({tag, ".vec"}, 32'(bus.ProjOnVec), vec);
    chk({tag, ".cnt"}, 32'(bus.ActiveCount), cnt);
    chk({tag, ".drop"}, 32'(bus.FireDropped), drop);
  endtask
  task automatic do_reset();
    Reset = 1'b0;
    bus.FireReq = '0;
    bus.ProjColl = '0;
    tick(1);
    Reset = 1'b1;
  endtask
  initial begin
    bus.FireReq = '0;
    bus.ShipX = '0;
    bus.ShipY = '0;
    bus.PlayerX = '0;
    bus.AimEn = 1'b0;
    bus.ProjColl = '0;
    bus.DrawX = '0;
    bus.DrawY = '0;
    #1;
    status("rst", 0, 0, 0);
    @(negedge frame_clk);
    Reset = 1'b1;
    bus.ShipX[0] = 10'd100;
    bus.ShipY[0] = 10'd50;
    bus.FireReq = 4'b0001;
    tick(1);
    status("launch", 8'h01, 1, 0);
    probe("launch_pos", 105, 57, 1'b1, 0, 0);
    probe("launch_in", 106, 62, 1'b1, 1, 5);
    probe("launch_xedge", 107, 57, 1'b0, 0, 0);
    probe("launch_yedge", 105, 63, 1'b0, 0, 0);
    tick(1);
    probe("move", 105, 59, 1'b1, 0, 0);
    probe("move_above", 105, 58, 1'b0, 0, 0);
    tick(29);
    status("cd_block", 8'h01, 1, 0);
    tick(1);
    status("cd_release", 8'h03, 2, 0);
    Reset = 1'b0;
    #1;
    status("async_rst", 0, 0, 0);
    bus.FireReq = '0;
    @(negedge frame_clk);
    Reset = 1'b1;
    bus.ShipX = {10'd400, 10'd300, 10'd200, 10'd100};
    bus.ShipY = {10'd50, 10'd50, 10'd50, 10'd50};
    bus.FireReq = 4'b1111;
    tick(1);
    status("fill4", 8'h0F, 4, 0);
    tick(30);
    status("fill_wait", 8'h0F, 4, 0);
    tick(1);
    status("fill8", 8'hFF, 8, 0);
    tick(30);
    status("full_cd", 8'hFF, 8, 0);
    tick(1);
    status("full_drop", 8'hFF, 8, 1);
    bus.FireReq = 4'b0011;
    tick(1);
    status("full_drop2", 8'hFF, 8, 1);
    bus.FireReq = 4'b0000;
    tick(1);
    status("drop_clear", 8'hFF, 8, 0);
    bus.FireReq = 4'b0001;
    bus.ProjColl = 8'h20;
    tick(1);
    status("coll5", 8'hDF, 7, 1);
    bus.ProjColl = 8'h00;
    tick(1);
    status("reuse5", 8'hFF, 8, 0);
    probe("reuse5_pos", 105, 57, 1'b1, 0, 0);
    bus.FireReq = 4'b0010;
    bus.ProjColl = 8'h08;
    tick(1);
    status("coll3", 8'hF7, 7, 1);
    bus.ProjColl = 8'h00;
    tick(1);
    status("reuse3", 8'hFF, 8, 0);
    probe("reuse3_pos", 205, 57, 1'b1, 0, 0);
    bus.FireReq = 4'b0000;
    do_reset();
    bus.AimEn = 1'b1;
    bus.PlayerX = 10'd700;
    bus.ShipX[0] = 10'd100;
    bus.ShipX[2] = 10'd620;
    bus.ShipY[0] = 10'd50;
    bus.ShipY[2] = 10'd50;
    bus.FireReq = 4'b0101;
    tick(1);
    bus.FireReq = 4'b0000;
    status("aim_launch", 8'h03, 2, 0);
    probe("aim_s0", 105, 57, 1'b1, 0, 0);
    probe("aim_s1", 625, 57, 1'b1, 0, 0);
    tick(1);
    probe("aim_move", 106, 59, 1'b1, 0, 0);
    probe("aim_old", 105, 59, 1'b0, 0, 0);
    tick(12);
    status("right_last", 8'h03, 2, 0);
    probe("right_pos", 638, 83, 1'b1, 0, 0);
    probe("right_in", 639, 88, 1'b1, 1, 5);
    tick(1);
    status("right_retire", 8'h01, 1, 0);
    tick(194);
    status("bottom_last", 8'h01, 1, 0);
    probe("bottom_pos", 313, 473, 1'b1, 0, 0);
    tick(1);
    status("bottom_retire", 8'h00, 0, 0);
    do_reset();
    bus.AimEn = 1'b0;
    bus.ShipX = {10'd400, 10'd300, 10'd200, 10'd100};
    bus.ShipY = {10'd50, 10'd50, 10'd50, 10'd50};
    bus.FireReq = 4'b1111;
    tick(31);
    bus.ShipX[1] = 10'd301;
    bus.ShipY[1] = 10'd112;
    tick(1);
    bus.FireReq = 4'b0000;
    status("ovl_fill", 8'hFF, 8, 0);
    probe("ovl_prio", 306, 120, 1'b1, 1, 1);
    probe("ovl_s5", 307, 124, 1'b1, 1, 5);
    probe("ovl_edge", 308, 120, 1'b0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
